// File: rtl/mem_arb_pkg.sv
// Shared definitions for the Sigma memory-port arbiter: ownership state
// encoding, bus field widths and the default mailbox handoff addresses.
// The optional MEM_ARB_STATS_EN build adds no package content.
package mem_arb_pkg;

  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 31;
  localparam int DATA_MSB = 0;
  localparam int DATA_LSB = 31;

  typedef logic [ADDR_MSB:ADDR_LSB] addr_t;
  typedef logic [DATA_MSB:DATA_LSB] data_t;
  typedef logic [0:3]               wen_t;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    TO_IOP  = 2'd1,
    IOP_OWN = 2'd2,
    TO_CPU  = 2'd3
  } arb_state_t;

  localparam addr_t DEFAULT_CPU_HANDOFF_ADDR = 17'h20;
  localparam addr_t DEFAULT_IOP_HANDOFF_ADDR = 17'h21;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the CPU request, IOP request and Memory-side signals around the
// arbiter. The slave modport is the arbiter's view; master is the view of
// whatever drives the two requesters and observes the Memory side.
interface mem_bus_arbiter_if;
  import mem_arb_pkg::*;

  logic  cpu_req;
  addr_t cpu_address;
  wen_t  cpu_write_en;
  data_t cpu_data;

  logic  iop_req;
  addr_t iop_address;
  wen_t  iop_write_en;
  data_t iop_data;

  addr_t mem_address;
  wen_t  mem_write_en;
  data_t mem_data_in;

  logic  cpu_active;
  logic  iop_grant;
  logic  forced_return;

  modport slave (
    input  cpu_req, cpu_address, cpu_write_en, cpu_data,
    input  iop_req, iop_address, iop_write_en, iop_data,
    output mem_address, mem_write_en, mem_data_in,
    output cpu_active, iop_grant, forced_return
  );

  modport master (
    output cpu_req, cpu_address, cpu_write_en, cpu_data,
    output iop_req, iop_address, iop_write_en, iop_data,
    input  mem_address, mem_write_en, mem_data_in,
    input  cpu_active, iop_grant, forced_return
  );

endinterface

// File: rtl/mem_arb_hold_timer.sv
// Saturating 16-bit hold counter. Counts while enabled, clears on demand,
// and flags when it sits at MAX_HOLD-1 so the owner can be evicted.
module mem_arb_hold_timer #(
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [15:0] TERMINAL_COUNT = 16'(MAX_HOLD - 1);

  logic [15:0] hold_cnt;

  // Count up while enabled, holding at all-ones instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (clear) begin
      hold_cnt <= '0;
    end else if (enable && (hold_cnt != 16'hFFFF)) begin
      hold_cnt <= hold_cnt + 16'd1;
    end
  end

  assign terminal = (hold_cnt == TERMINAL_COUNT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Ownership arbiter for the shared Sigma memory port between CPU and IOP.
// Ownership moves on a mailbox write, an idle/request condition or an IOP
// hold-limit timeout, with a one-cycle turnaround state in each direction.
// Define MEM_ARB_STATS_EN to add the cpu_cycles/iop_cycles/handoff_count
// statistics outputs.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter addr_t       CPU_HANDOFF_ADDR = DEFAULT_CPU_HANDOFF_ADDR,
  parameter addr_t       IOP_HANDOFF_ADDR = DEFAULT_IOP_HANDOFF_ADDR,
  parameter int unsigned MAX_HOLD         = 64
) (
  input  logic             clock,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [0:31]      cpu_cycles,
  output logic [0:31]      iop_cycles,
  output logic [0:15]      handoff_count
`endif
);

  arb_state_t state;
  arb_state_t next_state;

  addr_t mem_address;
  wen_t  mem_write_en;
  data_t mem_data_in;
  logic  cpu_active;
  logic  iop_grant;
  logic  forced_return;

  logic  cpu_mailbox;
  logic  iop_mailbox;
  logic  hold_terminal;
  logic  hold_clear;
  logic  hold_enable;

  assign cpu_mailbox = (bus.cpu_address == CPU_HANDOFF_ADDR) && bus.cpu_write_en[0];
  assign iop_mailbox = (bus.iop_address == IOP_HANDOFF_ADDR) && bus.iop_write_en[0];

  // The hold count only runs in IOP_OWN while the CPU is waiting.
  assign hold_enable = (state == IOP_OWN) && bus.cpu_req;
  assign hold_clear  = (state != IOP_OWN) || !bus.cpu_req;

  mem_arb_hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (hold_clear),
    .enable   (hold_enable),
    .terminal (hold_terminal)
  );

  // Ownership state register; reset hands the bus straight back to the CPU.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CPU_OWN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the bus mux; the mailbox beats the timeout.
  always_comb begin
    next_state    = state;
    mem_address   = bus.cpu_address;
    mem_write_en  = bus.cpu_write_en;
    mem_data_in   = bus.cpu_data;
    cpu_active    = 1'b0;
    iop_grant     = 1'b0;
    forced_return = 1'b0;
    case (state)
      CPU_OWN: begin
        cpu_active = 1'b1;
        if (cpu_mailbox || (bus.iop_req && !bus.cpu_req)) begin
          next_state = TO_IOP;
        end
      end
      TO_IOP: begin
        mem_address  = bus.iop_address;
        mem_write_en = 4'b0000;
        mem_data_in  = bus.iop_data;
        next_state   = IOP_OWN;
      end
      IOP_OWN: begin
        mem_address  = bus.iop_address;
        mem_write_en = bus.iop_write_en;
        mem_data_in  = bus.iop_data;
        iop_grant    = 1'b1;
        if (iop_mailbox) begin
          next_state = TO_CPU;
        end else if (bus.cpu_req && hold_terminal) begin
          next_state    = TO_CPU;
          forced_return = 1'b1;
        end else if (!bus.iop_req) begin
          next_state = TO_CPU;
        end
      end
      TO_CPU: begin
        mem_write_en = 4'b0000;
        next_state   = CPU_OWN;
      end
      default: begin
        next_state = CPU_OWN;
      end
    endcase
  end

  assign bus.mem_address   = mem_address;
  assign bus.mem_write_en  = mem_write_en;
  assign bus.mem_data_in   = mem_data_in;
  assign bus.cpu_active    = cpu_active;
  assign bus.iop_grant     = iop_grant;
  assign bus.forced_return = forced_return;

`ifdef MEM_ARB_STATS_EN
  logic handoff_entry;
  assign handoff_entry = (next_state == TO_IOP) || (next_state == TO_CPU);

  // Saturating occupancy and handoff statistics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_cycles    <= '0;
      iop_cycles    <= '0;
      handoff_count <= '0;
    end else begin
      if ((state == CPU_OWN) && (cpu_cycles != 32'hFFFF_FFFF)) begin
        cpu_cycles <= cpu_cycles + 32'd1;
      end
      if ((state == IOP_OWN) && (iop_cycles != 32'hFFFF_FFFF)) begin
        iop_cycles <= iop_cycles + 32'd1;
      end
      if (handoff_entry && (handoff_count != 16'hFFFF)) begin
        handoff_count <= handoff_count + 16'd1;
      end
    end
  end
`else
  // Statistics counters are absent; ownership behaviour is unchanged.
`endif

endmodule
